// File: rtl/sata_link_rx_frame_buffer.sv
// Receive-side frame buffer behind the SATA link-layer read engine.
// Payload dwords are written speculatively and become visible to the
// transport reader only when the frame is committed after a good CRC. Bad,
// aborted or overflowed frames are rolled back to the last committed end.
// Handshake: the link writes one dword per cycle while read_strobe=1 and
// holds off (HOLD) when read_ready=0; the consumer takes out_data on any
// cycle where out_valid=1 and out_pop=1.
module sata_link_rx_frame_buffer #(
    parameter int ADDR_WIDTH  = 9,
    parameter int HOLD_MARGIN = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_start,
    input  logic        read_strobe,
    input  logic [31:0] read_data,
    input  logic        read_finished,
    input  logic        crc_ok,
    input  logic        remote_abort,
    output logic        read_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_pop,
    output logic [7:0]  frame_count,
    output logic        frame_good,
    output logic        frame_bad,
    output logic        overflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t state, state_next;
    ptr_t   wr_ptr, cm_ptr, rd_ptr, len;
    ptr_t   wr_next, cm_next, rd_next, len_next;
    ptr_t   used, used_next, free_next;
    logic   full, do_write, do_commit, do_pop, pop_last;
    logic   overflow_next, good_next, bad_next, ready_next;
    logic [ADDR_WIDTH-1:0] last_idx;

    logic [31:0] mem      [DEPTH];
    logic        last_mem [DEPTH];
    logic [31:0] ram_q;
    logic        last_q;

    assign used      = wr_ptr - rd_ptr;
    assign full      = (used == ptr_t'(DEPTH));
    assign out_valid = (rd_ptr != cm_ptr);
    assign out_data  = ram_q;
    assign out_last  = out_valid & last_q;
    assign do_pop    = out_valid & out_pop;
    assign pop_last  = do_pop & out_last;
    assign rd_next   = do_pop ? rd_ptr + ptr_t'(1) : rd_ptr;
    // Final entry of the frame being committed (cm_ptr_new - 1).
    assign last_idx  = wr_ptr[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    // Frame state machine: next state, pointer updates and status pulses.
    always_comb begin
        state_next    = state;
        wr_next       = wr_ptr;
        cm_next       = cm_ptr;
        len_next      = len;
        overflow_next = overflow;
        good_next     = 1'b0;
        bad_next      = 1'b0;
        do_write      = 1'b0;
        do_commit     = 1'b0;
        case (state)
            IDLE: begin
                if (read_start) begin
                    state_next    = RECV;
                    wr_next       = cm_ptr;
                    overflow_next = 1'b0;
                    len_next      = '0;
                end
            end
            RECV: begin
                if (remote_abort) begin
                    wr_next    = cm_ptr;
                    bad_next   = 1'b1;
                    state_next = IDLE;
                end else if (read_start) begin
                    // Restart: silently discard the partial frame.
                    wr_next       = cm_ptr;
                    overflow_next = 1'b0;
                    len_next      = '0;
                end else begin
                    if (read_strobe) begin
                        if (!full) begin
                            do_write = 1'b1;
                            wr_next  = wr_ptr + ptr_t'(1);
                            len_next = len + ptr_t'(1);
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                    if (read_finished) state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (crc_ok && !overflow && (len != '0)) begin
                    cm_next   = wr_ptr;
                    do_commit = 1'b1;
                    good_next = 1'b1;
                end else begin
                    wr_next  = cm_ptr;
                    bad_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Back-pressure looks at the pointers as they will be after this cycle.
    always_comb begin
        used_next  = wr_next - rd_next;
        free_next  = ptr_t'(DEPTH) - used_next;
        ready_next = (free_next >= ptr_t'(HOLD_MARGIN)) && (state_next != CHECK);
    end

    // Control registers, pointers, frame counter and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            rd_ptr      <= '0;
            len         <= '0;
            overflow    <= 1'b0;
            frame_good  <= 1'b0;
            frame_bad   <= 1'b0;
            read_ready  <= 1'b1;
            frame_count <= 8'd0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_next;
            cm_ptr     <= cm_next;
            rd_ptr     <= rd_next;
            len        <= len_next;
            overflow   <= overflow_next;
            frame_good <= good_next;
            frame_bad  <= bad_next;
            read_ready <= ready_next;
            if (do_commit && pop_last) begin
                frame_count <= frame_count;
            end else if (do_commit) begin
                if (frame_count != 8'd255) frame_count <= frame_count + 8'd1;
            end else if (pop_last && (frame_count != 8'd0)) begin
                frame_count <= frame_count - 8'd1;
            end
        end
    end

    // Data RAM with registered read of the next head entry (fall-through).
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[ADDR_WIDTH-1:0]] <= read_data;
        ram_q <= mem[rd_next[ADDR_WIDTH-1:0]];
    end

    // Last-bit array: cleared on each data write, set on the final entry at commit.
    always_ff @(posedge clk) begin
        if (do_write) begin
            last_mem[wr_ptr[ADDR_WIDTH-1:0]] <= 1'b0;
        end else if (do_commit) begin
            last_mem[last_idx] <= 1'b1;
        end
    end

    // Registered last-bit read; bypass covers a commit landing on the next head.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (do_commit && (last_idx == rd_next[ADDR_WIDTH-1:0])) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_mem[rd_next[ADDR_WIDTH-1:0]];
        end
    end

endmodule

// File: tb/tb_sata_link_rx_frame_buffer.sv
// Directed bench for sata_link_rx_frame_buffer. Inputs change 1 time unit
// after the rising edge and outputs are sampled at that same point.
module tb_sata_link_rx_frame_buffer;
    logic        clk;
    logic        rst;
    logic        read_start;
    logic        read_strobe;
    logic [31:0] read_data;
    logic        read_finished;
    logic        crc_ok;
    logic        remote_abort;
    logic        read_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_pop;
    logic [7:0]  frame_count;
    logic        frame_good;
    logic        frame_bad;
    logic        overflow;

    int checks = 0;
    int passed = 0;

    sata_link_rx_frame_buffer #(.ADDR_WIDTH(9), .HOLD_MARGIN(20)) dut (
        .clk(clk), .rst(rst),
        .read_start(read_start), .read_strobe(read_strobe), .read_data(read_data),
        .read_finished(read_finished), .crc_ok(crc_ok), .remote_abort(remote_abort),
        .read_ready(read_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_pop(out_pop), .frame_count(frame_count),
        .frame_good(frame_good), .frame_bad(frame_bad), .overflow(overflow)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
    endtask

    task automatic strobe_word(input logic [31:0] d, input logic fin);
        read_strobe   = 1'b1;
        read_data     = d;
        read_finished = fin;
        tick();
        read_strobe   = 1'b0;
        read_finished = 1'b0;
    endtask

    task automatic finish_only();
        read_finished = 1'b1;
        tick();
        read_finished = 1'b0;
    endtask

    task automatic crc_cycle(input logic ok);
        crc_ok = ok;
        tick();
        crc_ok = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input logic ok);
        start_frame();
        for (int i = 0; i < n; i++) strobe_word(base + 32'(i), i == n - 1);
        crc_cycle(ok);
    endtask

    task automatic pop_word();
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %0b exp 0", out_last); else passed++;
        checks++; if (read_ready !== 1'b1) $display("FAIL reset_read_ready got %0b exp 1", read_ready); else passed++;
        checks++; if (frame_count !== 8'd0) $display("FAIL reset_frame_count got %0d exp 0", frame_count); else passed++;
        checks++; if ({frame_good, frame_bad, overflow} !== 3'b000)
            $display("FAIL reset_pulses got %b exp 000", {frame_good, frame_bad, overflow}); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        logic [31:0] d [4];
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
        start_frame();
        for (int i = 0; i < 4; i++) strobe_word(d[i], i == 3);
        crc_cycle(1'b1);
        checks++; if (frame_good !== 1'b1) $display("FAIL good_frame_good got %0b exp 1", frame_good); else passed++;
        checks++; if (frame_bad !== 1'b0) $display("FAIL good_frame_bad got %0b exp 0", frame_bad); else passed++;
        checks++; if (frame_count !== 8'd1) $display("FAIL good_frame_count got %0d exp 1", frame_count); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL good_valid[%0d] got %0b exp 1", i, out_valid); else passed++;
            checks++; if (out_data !== d[i]) $display("FAIL good_data[%0d] got %h exp %h", i, out_data, d[i]); else passed++;
            checks++; if (out_last !== (i == 3)) $display("FAIL good_last[%0d] got %0b exp %0b", i, out_last, i == 3); else passed++;
            pop_word();
            if (i == 0) begin
                checks++; if (frame_good !== 1'b0) $display("FAIL good_pulse_once got %0b exp 0", frame_good); else passed++;
            end
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL good_drained got %0b exp 0", out_valid); else passed++;
        checks++; if (frame_count !== 8'd0) $display("FAIL good_count_after got %0d exp 0", frame_count); else passed++;
    endtask

    task automatic test_bad_crc();
        start_frame();
        strobe_word(32'h11, 1'b0); strobe_word(32'h22, 1'b0);
        strobe_word(32'h33, 1'b0); strobe_word(32'h44, 1'b1);
        crc_cycle(1'b0);
        checks++; if (frame_bad !== 1'b1) $display("FAIL badcrc_frame_bad got %0b exp 1", frame_bad); else passed++;
        checks++; if (frame_good !== 1'b0) $display("FAIL badcrc_frame_good got %0b exp 0", frame_good); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL badcrc_out_valid got %0b exp 0", out_valid); else passed++;
        checks++; if (frame_count !== 8'd0) $display("FAIL badcrc_count got %0d exp 0", frame_count); else passed++;
        tick();
        checks++; if (frame_bad !== 1'b0) $display("FAIL badcrc_pulse_once got %0b exp 0", frame_bad); else passed++;
        send_frame(3, 32'hA0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data !== 32'hA0 + 32'(i))
                $display("FAIL badcrc_next_data[%0d] got %h exp %h", i, out_data, 32'hA0 + 32'(i)); else passed++;
            pop_word();
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL badcrc_next_drained got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_hold_margin();
        int errs = 0;
        start_frame();
        for (int i = 0; i < 493; i++) begin
            strobe_word(32'h3000_0000 + 32'(i), 1'b0);
            if (i == 491) begin
                checks++; if (read_ready !== 1'b1) $display("FAIL hold_ready_492 got %0b exp 1", read_ready); else passed++;
            end
            if (i == 492) begin
                checks++; if (read_ready !== 1'b0) $display("FAIL hold_ready_493 got %0b exp 0", read_ready); else passed++;
            end
        end
        finish_only();
        crc_cycle(1'b1);
        checks++; if (frame_good !== 1'b1) $display("FAIL hold_frame_good got %0b exp 1", frame_good); else passed++;
        checks++; if (read_ready !== 1'b0) $display("FAIL hold_ready_idle got %0b exp 0", read_ready); else passed++;
        checks++; if (out_data !== 32'h3000_0000) $display("FAIL hold_first_data got %h exp 30000000", out_data); else passed++;
        pop_word();
        checks++; if (read_ready !== 1'b1) $display("FAIL hold_ready_after_pop got %0b exp 1", read_ready); else passed++;
        for (int i = 1; i < 493; i++) begin
            if (out_valid !== 1'b1 || out_data !== 32'h3000_0000 + 32'(i) || out_last !== (i == 492)) errs++;
            pop_word();
        end
        checks++; if (errs != 0) $display("FAIL hold_drain_errors got %0d exp 0", errs); else passed++;
        checks++; if (frame_count !== 8'd0) $display("FAIL hold_count_after got %0d exp 0", frame_count); else passed++;
    endtask

    task automatic test_overflow();
        start_frame();
        for (int i = 0; i < 513; i++) begin
            strobe_word(32'h4000_0000 + 32'(i), 1'b0);
            if (i == 511) begin
                checks++; if (overflow !== 1'b0) $display("FAIL ovf_at_512 got %0b exp 0", overflow); else passed++;
                checks++; if (read_ready !== 1'b0) $display("FAIL ovf_ready_full got %0b exp 0", read_ready); else passed++;
            end
            if (i == 512) begin
                checks++; if (overflow !== 1'b1) $display("FAIL ovf_at_513 got %0b exp 1", overflow); else passed++;
            end
        end
        finish_only();
        crc_cycle(1'b1);
        checks++; if (frame_bad !== 1'b1) $display("FAIL ovf_frame_bad got %0b exp 1", frame_bad); else passed++;
        checks++; if (frame_good !== 1'b0) $display("FAIL ovf_frame_good got %0b exp 0", frame_good); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL ovf_out_valid got %0b exp 0", out_valid); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", overflow); else passed++;
        checks++; if (read_ready !== 1'b1) $display("FAIL ovf_ready_restored got %0b exp 1", read_ready); else passed++;
        start_frame();
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared_by_start got %0b exp 0", overflow); else passed++;
        strobe_word(32'hC0, 1'b0);
        strobe_word(32'hC1, 1'b1);
        crc_cycle(1'b1);
        checks++; if (frame_good !== 1'b1) $display("FAIL ovf_next_good got %0b exp 1", frame_good); else passed++;
        checks++; if (out_data !== 32'hC0) $display("FAIL ovf_next_data0 got %h exp c0", out_data); else passed++;
        pop_word();
        checks++; if (out_data !== 32'hC1 || out_last !== 1'b1)
            $display("FAIL ovf_next_data1 got %h/%0b exp c1/1", out_data, out_last); else passed++;
        pop_word();
        checks++; if (out_valid !== 1'b0) $display("FAIL ovf_next_drained got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_abort();
        start_frame();
        strobe_word(32'hD0, 1'b0); strobe_word(32'hD1, 1'b0); strobe_word(32'hD2, 1'b0);
        remote_abort = 1'b1;
        tick();
        remote_abort = 1'b0;
        checks++; if (frame_bad !== 1'b1) $display("FAIL abort_frame_bad got %0b exp 1", frame_bad); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got %0b exp 0", out_valid); else passed++;
        send_frame(2, 32'hE0, 1'b1);
        checks++; if (frame_count !== 8'd1) $display("FAIL abort_count got %0d exp 1", frame_count); else passed++;
        checks++; if (out_data !== 32'hE0 || out_last !== 1'b0)
            $display("FAIL abort_data0 got %h/%0b exp e0/0", out_data, out_last); else passed++;
        pop_word();
        checks++; if (out_data !== 32'hE1 || out_last !== 1'b1)
            $display("FAIL abort_data1 got %h/%0b exp e1/1", out_data, out_last); else passed++;
        pop_word();
        checks++; if (out_valid !== 1'b0) $display("FAIL abort_drained got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [8];
        logic        exp_l [8];
        int          errs = 0;
        send_frame(6, 32'hF0, 1'b1);
        checks++; if (frame_count !== 8'd1) $display("FAIL b2b_count_a got %0d exp 1", frame_count); else passed++;
        start_frame();
        // Receive frame B while popping the first five dwords of frame A.
        for (int i = 0; i < 5; i++) begin
            if (out_data !== 32'hF0 + 32'(i)) errs++;
            out_pop       = 1'b1;
            read_strobe   = 1'b1;
            read_data     = 32'hB0 + 32'(i);
            read_finished = (i == 4);
            tick();
            out_pop = 1'b0; read_strobe = 1'b0; read_finished = 1'b0;
        end
        checks++; if (errs != 0) $display("FAIL b2b_overlap_pops got %0d errors exp 0", errs); else passed++;
        checks++; if (out_data !== 32'hF5 || out_last !== 1'b1)
            $display("FAIL b2b_a_final got %h/%0b exp f5/1", out_data, out_last); else passed++;
        // Commit of B coincides with the pop of A's final dword.
        crc_ok  = 1'b1;
        out_pop = 1'b1;
        tick();
        crc_ok = 1'b0; out_pop = 1'b0;
        checks++; if (frame_good !== 1'b1) $display("FAIL b2b_good_b got %0b exp 1", frame_good); else passed++;
        checks++; if (frame_count !== 8'd1) $display("FAIL b2b_count_net0 got %0d exp 1", frame_count); else passed++;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hB0 || out_last !== 1'b0)
            $display("FAIL b2b_head_b got %0b/%h/%0b exp 1/b0/0", out_valid, out_data, out_last); else passed++;
        send_frame(3, 32'hC8, 1'b1);
        checks++; if (frame_count !== 8'd2) $display("FAIL b2b_count_c got %0d exp 2", frame_count); else passed++;
        for (int i = 0; i < 5; i++) begin exp_d[i] = 32'hB0 + 32'(i); exp_l[i] = (i == 4); end
        for (int i = 0; i < 3; i++) begin exp_d[5+i] = 32'hC8 + 32'(i); exp_l[5+i] = (i == 2); end
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== exp_l[i]) errs++;
            pop_word();
            if (i == 4) begin
                checks++; if (frame_count !== 8'd1) $display("FAIL b2b_count_after_b got %0d exp 1", frame_count); else passed++;
            end
        end
        checks++; if (errs != 0) $display("FAIL b2b_drain got %0d errors exp 0", errs); else passed++;
        checks++; if (out_valid !== 1'b0 || frame_count !== 8'd0)
            $display("FAIL b2b_empty got %0b/%0d exp 0/0", out_valid, frame_count); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        start_frame();
        strobe_word(32'h55, 1'b0);
        strobe_word(32'h66, 1'b0);
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || frame_bad !== 1'b0)
            $display("FAIL midrst_outputs got %0b/%0b exp 0/0", out_valid, frame_bad); else passed++;
        checks++; if (read_ready !== 1'b1 || frame_count !== 8'd0 || overflow !== 1'b0)
            $display("FAIL midrst_status got %0b/%0d/%0b exp 1/0/0", read_ready, frame_count, overflow); else passed++;
        rst = 1'b0;
        tick();
        checks++; if (frame_bad !== 1'b0) $display("FAIL midrst_no_bad_pulse got %0b exp 0", frame_bad); else passed++;
        send_frame(1, 32'h77, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h77 || out_last !== 1'b1)
            $display("FAIL midrst_single got %0b/%h/%0b exp 1/77/1", out_valid, out_data, out_last); else passed++;
        pop_word();
        checks++; if (out_valid !== 1'b0) $display("FAIL midrst_drained got %0b exp 0", out_valid); else passed++;
    endtask

    // Test sequence and final report.
    initial begin
        rst = 1'b1; read_start = 1'b0; read_strobe = 1'b0; read_data = 32'h0;
        read_finished = 1'b0; crc_ok = 1'b0; remote_abort = 1'b0; out_pop = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_hold_margin();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
